// File: rtl/mpb_mem_responder_pkg.sv
// Shared types and helpers for the MPB memory responder.
// Optional error counter is enabled by defining MPB_MEM_RESPONDER_ERR_CNT_EN.
package mpb_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WAIT_CNT_W = 4;

  // A request errors when it is not word aligned or falls past the last word.
  function automatic logic addr_err(input logic [63:0] addr, input int depth, input int data_w);
    logic [63:0] lane_mask;
    logic [63:0] limit;
    lane_mask = 64'(data_w / 8 - 1);
    limit     = 64'(depth) * 64'(data_w / 8);
    return ((addr & lane_mask) != 64'd0) || (addr >= limit);
  endfunction

endpackage

// File: rtl/mpb_mem_responder_mem.sv
// DEPTH x DATA_W register array: async clear, byte-enabled write, combinational read.
module mpb_mem_responder_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem_d[wr_idx][8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/mpb_mem_responder.sv
// MPB target: one outstanding request, optional wait cycles, byte-enabled word memory.
// Define MPB_MEM_RESPONDER_ERR_CNT_EN to add the saturating err_cnt output and err_cnt_clr input.
module mpb_mem_responder
  import mpb_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
  ,
  input  logic                err_cnt_clr,
  output logic [7:0]          err_cnt
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    req_rdy_q, req_rdy_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    accept;
  logic                    rsp_hs;
  logic                    req_err;
  logic [IDX_W-1:0]        req_idx;
  logic [DATA_W-1:0]       mem_rdata;

  assign accept  = req_vld && req_rdy_q;
  assign rsp_hs  = rsp_vld_q && rsp_rdy;
  assign req_err = addr_err(64'(req_addr), DEPTH, DATA_W);
  assign req_idx = req_addr[OFF_W +: IDX_W];

  // Writes land in the accept cycle so a following read sees them.
  mpb_mem_responder_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accept && req_we && !req_err),
    .wr_idx  (req_idx),
    .wr_data (req_wdata),
    .wr_be   (req_be),
    .rd_idx  (req_idx),
    .rd_data (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_err_d   = req_err;
          rsp_rdata_d = (!req_we && !req_err) ? mem_rdata : '0;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      RESP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_vld_d = (state_d == RESP);
    req_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_rdy_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_rdy_q   <= req_rdy_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_rdy   = req_rdy_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Clear wins over a same-cycle increment; the count sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr)                                       err_cnt_d = 8'd0;
    else if (rsp_hs && rsp_err_q && err_cnt_q != 8'hFF)    err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= 8'd0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mpb_mem_responder.sv
// Directed bench: u_dut0 runs with no wait cycles, u_dut3 with three.
module tb_mpb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        req_vld0, req_we0, rsp_rdy0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        req_rdy0, rsp_vld0, rsp_err0;
  logic [31:0] rsp_rdata0;

  logic        req_vld3, req_we3, rsp_rdy3;
  logic [31:0] req_addr3, req_wdata3;
  logic [3:0]  req_be3;
  logic        req_rdy3, rsp_vld3, rsp_err3;
  logic [31:0] rsp_rdata3;

`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
  logic        err_cnt_clr0, err_cnt_clr3, clr_at_hs;
  logic [7:0]  err_cnt0, err_cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mpb_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_vld   (req_vld0),
    .req_rdy   (req_rdy0),
    .req_we    (req_we0),
    .req_addr  (req_addr0),
    .req_wdata (req_wdata0),
    .req_be    (req_be0),
    .rsp_vld   (rsp_vld0),
    .rsp_rdy   (rsp_rdy0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    ,
    .err_cnt_clr (err_cnt_clr0),
    .err_cnt     (err_cnt0)
`endif
  );

  mpb_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)) u_dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_vld   (req_vld3),
    .req_rdy   (req_rdy3),
    .req_we    (req_we3),
    .req_addr  (req_addr3),
    .req_wdata (req_wdata3),
    .req_be    (req_be3),
    .rsp_vld   (rsp_vld3),
    .rsp_rdy   (rsp_rdy3),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3)
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    ,
    .err_cnt_clr (err_cnt_clr3),
    .err_cnt     (err_cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on u_dut0 with rsp_rdy held high; response is due one cycle after accept.
  task automatic xact0(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_er);
    int n = 0;
    int lat;
    while (!req_rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_rdy"}, 32'(req_rdy0), 32'd1);
    req_vld0   = 1'b1;
    req_we0    = we;
    req_addr0  = addr;
    req_wdata0 = wdata;
    req_be0    = be;
    @(posedge clk);
    #1;
    req_vld0   = 1'b0;
    req_we0    = $urandom_range(0, 1) == 1;
    req_addr0  = $urandom;
    req_wdata0 = $urandom;
    req_be0    = 4'($urandom_range(0, 15));
    @(negedge clk);
    lat = 1;
    while (!rsp_vld0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata0, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err0), 32'(exp_er));
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    if (clr_at_hs) err_cnt_clr0 = 1'b1;
`endif
    @(posedge clk);
    #1;
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    err_cnt_clr0 = 1'b0;
`endif
    chk({tag, "_vld_drop"}, 32'(rsp_vld0), 32'd0);
    chk({tag, "_b2b_rdy"}, 32'(req_rdy0), 32'd1);
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    req_vld0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0; rsp_rdy0 = 1'b1;
    req_vld3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; req_be3 = '0; rsp_rdy3 = 1'b1;
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    err_cnt_clr0 = 1'b0; err_cnt_clr3 = 1'b0; clr_at_hs = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy0), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld0), 32'd0);
    chk("rst_rdata", rsp_rdata0, 32'd0);
    chk("rst_err", 32'(rsp_err0), 32'd0);
`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt0), 32'd0);
`endif
    reset_n = 1'b1;
    #1;
    chk("rel_req_rdy_low", 32'(req_rdy0), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_req_rdy0_high", 32'(req_rdy0), 32'd1);
    chk("rel_req_rdy3_high", 32'(req_rdy3), 32'd1);

    xact0("wr4", 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact0("rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    xact0("wr8_full", 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    xact0("wr8_part", 1'b1, 32'h8, 32'h00000000, 4'h5, 32'h0, 1'b0);
    xact0("rd8", 1'b0, 32'h8, 32'h0, 4'hF, 32'hFF00FF00, 1'b0);

    xact0("rd40_oor", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1);
    xact0("wr6_mis", 1'b1, 32'h6, 32'h12345678, 4'hF, 32'h0, 1'b1);
    xact0("rd4_after_err", 1'b0, 32'h4, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    xact0("rd3c_last", 1'b0, 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0);
    xact0("wr4_be0", 1'b1, 32'h4, 32'h11111111, 4'h0, 32'h0, 1'b0);
    xact0("rd4_after_be0", 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

`ifdef MPB_MEM_RESPONDER_ERR_CNT_EN
    chk("err_cnt_two", 32'(err_cnt0), 32'd2);
    err_cnt_clr0 = 1'b1;
    @(posedge clk);
    #1;
    err_cnt_clr0 = 1'b0;
    chk("err_cnt_clr", 32'(err_cnt0), 32'd0);
    for (int i = 0; i < 260; i++) xact0("sat_err", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1);
    chk("err_cnt_sat", 32'(err_cnt0), 32'd255);
    clr_at_hs = 1'b1;
    xact0("clr_vs_inc", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1);
    clr_at_hs = 1'b0;
    chk("err_cnt_clr_prio", 32'(err_cnt0), 32'd0);
    xact0("err_after_clr", 1'b1, 32'h41, 32'h0, 4'hF, 32'h0, 1'b1);
    chk("err_cnt_one", 32'(err_cnt0), 32'd1);
`endif

    // Prime u_dut3 with a known word, then read it back under backpressure.
    req_vld3 = 1'b1; req_we3 = 1'b1; req_addr3 = 32'h10; req_wdata3 = 32'hCAFEF00D; req_be3 = 4'hF;
    @(posedge clk);
    #1;
    req_vld3 = 1'b0; req_we3 = 1'b0;
    n = 0;
    while (!rsp_vld3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d3_wr_vld", 32'(rsp_vld3), 32'd1);
    chk("d3_wr_err", 32'(rsp_err3), 32'd0);
    @(posedge clk);
    #1;

    rsp_rdy3 = 1'b0;
    req_vld3 = 1'b1; req_we3 = 1'b0; req_addr3 = 32'h10; req_be3 = 4'h0;
    @(posedge clk);
    #1;
    req_vld3 = 1'b0; req_addr3 = 32'h6;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("bp_vld_wait", 32'(rsp_vld3), 32'd0);
      end else begin
        chk("bp_vld_hold", 32'(rsp_vld3), 32'd1);
        chk("bp_rdata_hold", rsp_rdata3, 32'hCAFEF00D);
        chk("bp_err_hold", 32'(rsp_err3), 32'd0);
      end
      chk("bp_req_rdy_low", 32'(req_rdy3), 32'd0);
    end
    rsp_rdy3 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_vld_after_hs", 32'(rsp_vld3), 32'd0);
    chk("bp_req_rdy_after_hs", 32'(req_rdy3), 32'd1);

    // u_dut0 parked in RESP and u_dut3 in WAIT when reset hits.
    rsp_rdy0 = 1'b0;
    req_vld0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h4; req_be0 = 4'hF;
    req_vld3 = 1'b1; req_we3 = 1'b0; req_addr3 = 32'h10; req_be3 = 4'hF;
    @(posedge clk);
    #1;
    req_vld0 = 1'b0;
    req_vld3 = 1'b0;
    @(negedge clk);
    chk("mid_resp_vld0", 32'(rsp_vld0), 32'd1);
    chk("mid_resp_rdata0", rsp_rdata0, 32'hDEADBEEF);
    chk("mid_wait_vld3", 32'(rsp_vld3), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_vld0", 32'(rsp_vld0), 32'd0);
    chk("arst_rdata0", rsp_rdata0, 32'd0);
    chk("arst_req_rdy0", 32'(req_rdy0), 32'd0);
    chk("arst_req_rdy3", 32'(req_rdy3), 32'd0);
    chk("arst_vld3", 32'(rsp_vld3), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    rsp_rdy0 = 1'b1;
    @(posedge clk);
    #1;
    xact0("rd4_post_rst", 1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    chk("abandoned_vld3", 32'(rsp_vld3), 32'd0);
    chk("idle_req_rdy3", 32'(req_rdy3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpb_mem_responder.md
Name: mpb_mem_responder

Overview:
- Synthesizable Matrix Peripheral Bus (MPB) target/responder: accepts MPB requests from an initiator, performs byte-enabled reads/writes on a small internal word memory, and returns one response per request.
- Sits at the slave end of the MPB link that the MPB agent interface observes.
- Serves as the DUT-side responder for agent loopback benches and as a scratch peripheral in integration.

Parameters:
- ADDR_W, 32, request byte-address width
- DATA_W, 32, data width; multiple of 8; byte-enable width is DATA_W/8
- DEPTH, 16, number of memory words; power of 2, at least 2
- WAIT_CYCLES, 0, extra cycles inserted between request accept and response valid; range 0..15

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  responder can accept request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  initiator accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  1 = misaligned or out-of-range access

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: req_rdy=0, rsp_vld=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0, all memory words=0. req_rdy rises in the first cycle after reset_n deasserts.
- Request handshake: a request is accepted on a rising edge where req_vld && req_rdy. req_rdy=1 only in IDLE, so at most one request is outstanding (no pipelining).
- FSM:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0, else go to RESP. The address, we, wdata and be are captured at accept.
  - WAIT: the counter is loaded with WAIT_CYCLES-1 at accept and decrements each cycle. Move to RESP when it reaches 0.
  - RESP: rsp_vld=1. rsp_vld, rsp_rdata and rsp_err stay stable until rsp_vld && rsp_rdy, then return to IDLE.
- Latency: with request accepted at edge T, rsp_vld is high from cycle T+1+WAIT_CYCLES.
- Back-to-back: after the response handshake at edge R, req_rdy=1 in cycle R+1. The minimum spacing between accepts is 2+WAIT_CYCLES cycles.
- Address decode:
  - Misaligned: addr[log2(DATA_W/8)-1:0]!=0 gives err.
  - Out of range: addr >= DEPTH*DATA_W/8 gives err.
  - On error: no memory update, rsp_rdata=0, rsp_err=1.
- Write: each byte lane i with be[i]=1 is updated from wdata. The write is committed in the accept cycle; a subsequent read returns the new data. be=0 is a legal no-op with err=0. rsp_rdata=0 for writes.
- Read: the full word is returned regardless of be and captured at accept. rsp_err=0 when in range.
- rsp_rdy held high before rsp_vld: harmless. The handshake completes in the first rsp_vld cycle.
- req_vld dropped while req_rdy=0: no effect. Values of req_* while not accepted are ignored.
- Asynchronous reset mid-WAIT or mid-RESP: the response is abandoned, memory is cleared and all outputs take their reset values immediately.

Optional Feature:
- Macro: MPB_MEM_RESPONDER_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, 8 bits, reset 0.
  - Increments on each completed response handshake with rsp_err=1.
  - Saturates at 255.
  - Adds input err_cnt_clr, 1 bit; clr has priority over an increment in the same cycle.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Package mpb_mem_responder_pkg:
  - state enum (IDLE, WAIT, RESP)
  - WAIT counter width constant (4)
  - function computing the error condition from addr, DEPTH and DATA_W
- Sub-module mpb_mem_responder_mem: DEPTH x DATA_W register array with async clear, byte-enable write port and combinational read port.

Test Plan:
- Reset then write: after reset, rsp_vld=0 and req_rdy=1 one cycle after reset_n rises. Write addr=0x4, wdata=0xDEADBEEF, be=0xF, WAIT_CYCLES=0 -> rsp_vld at T+1, err=0, rdata=0. Read addr=0x4 -> rdata=0xDEADBEEF.
- Partial write: write addr=0x8, wdata=0xFFFFFFFF, be=0xF. Then write wdata=0x00000000, be=0x5. Read addr=0x8 -> 0xFF00FF00.
- Errors:
  - Read addr=0x40 (DEPTH=16) -> err=1, rdata=0.
  - Write addr=0x6 -> err=1, memory unchanged.
  - With ERR_CNT_EN defined, err_cnt=2 after both.
- Response backpressure: WAIT_CYCLES=3, hold rsp_rdy=0 for 5 cycles -> rsp_vld asserts at T+4 and holds with stable rdata and err; req_rdy=0 throughout; handshake on rsp_rdy=1, then req_rdy=1 the next cycle.
- Reset mid-operation: assert reset_n=0 during WAIT -> rsp_vld and req_rdy drop immediately. Read addr=0x4 after reset -> 0x00000000.
- Counter saturation (ERR_CNT_EN): 260 error responses -> err_cnt=255. err_cnt_clr pulsed in the same cycle as an error handshake -> err_cnt=0.
